lsu_arbiter: RTL

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arbiter_if.sv | 42 ++++
 rtl/lsu_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lsu_arbiter_if.sv
// Bus bundle between the two LSU requesters, the arbiter and the LSU.
// The slave modport is the arbiter's view; master is the requester/LSU side.
interface lsu_arbiter_if;
  logic        i_req0;
  logic        i_req1;
  logic        i_wren0;
  logic        i_wren1;
  logic [31:0] i_addr0;
  logic [31:0] i_addr1;
  logic [31:0] i_wdata0;
  logic [31:0] i_wdata1;
  logic [3:0]  i_mask0;
  logic [3:0]  i_mask1;
  logic        i_lock0;
  logic        i_lock1;
  logic        o_gnt0;
  logic        o_gnt1;
  logic        o_rvalid0;
  logic        o_rvalid1;
  logic [31:0] o_rdata;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_lsu_stdata;
  logic        o_lsu_wren;
  logic [3:0]  o_lsu_mask;
  logic [31:0] i_lsu_lddata;

  modport slave (
    input  i_req0, i_req1, i_wren0, i_wren1, i_addr0, i_addr1,
           i_wdata0, i_wdata1, i_mask0, i_mask1, i_lock0, i_lock1,
           i_lsu_lddata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
           o_lsu_addr, o_lsu_stdata, o_lsu_wren, o_lsu_mask
  );

  modport master (
    output i_req0, i_req1, i_wren0, i_wren1, i_addr0, i_addr1,
           i_wdata0, i_wdata1, i_mask0, i_mask1, i_lock0, i_lock1,
           i_lsu_lddata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata,
           o_lsu_addr, o_lsu_stdata, o_lsu_wren, o_lsu_mask
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-port round-robin arbiter in front of a single LSU, with bounded lock bursts
// and a registered, shared load-data return path.
module lsu_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  lsu_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  logic [1:0]  owner;
  logic [1:0]  owner_nxt;
  logic        ptr;
  logic        ptr_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        gnt0;
  logic        gnt1;
  logic        rel0;
  logic        rel1;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata;

  assign gnt0 = (owner == OWN0) & bus.i_req0;
  assign gnt1 = (owner == OWN1) & bus.i_req1;

  assign rel0 = ~bus.i_req0 | ~bus.i_lock0 | (cnt == LAST_BEAT);
  assign rel1 = ~bus.i_req1 | ~bus.i_lock1 | (cnt == LAST_BEAT);

  // Release hands straight to the other port when it is waiting, so the
  // handoff costs no idle cycle.
  always_comb begin
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (owner)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.i_req0 & bus.i_req1) owner_nxt = ptr ? OWN1 : OWN0;
        else if (bus.i_req0)         owner_nxt = OWN0;
        else if (bus.i_req1)         owner_nxt = OWN1;
      end
      OWN0: begin
        if (rel0) begin
          owner_nxt = bus.i_req1 ? OWN1 : IDLE;
          ptr_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      OWN1: begin
        if (rel1) begin
          owner_nxt = bus.i_req0 ? OWN0 : IDLE;
          ptr_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        owner_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      owner <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grants are mutually exclusive, so one shared data register serves both ports.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= gnt0 & ~bus.i_wren0;
      rvalid1 <= gnt1 & ~bus.i_wren1;
      if ((gnt0 & ~bus.i_wren0) | (gnt1 & ~bus.i_wren1)) rdata <= bus.i_lsu_lddata;
    end
  end

  always_comb begin
    bus.o_lsu_addr   = '0;
    bus.o_lsu_stdata = '0;
    bus.o_lsu_wren   = 1'b0;
    bus.o_lsu_mask   = '0;
    case (owner)
      OWN0: begin
        bus.o_lsu_addr   = bus.i_addr0;
        bus.o_lsu_stdata = bus.i_wdata0;
        bus.o_lsu_wren   = bus.i_wren0 & bus.i_req0;
        bus.o_lsu_mask   = bus.i_req0 ? bus.i_mask0 : '0;
      end
      OWN1: begin
        bus.o_lsu_addr   = bus.i_addr1;
        bus.o_lsu_stdata = bus.i_wdata1;
        bus.o_lsu_wren   = bus.i_wren1 & bus.i_req1;
        bus.o_lsu_mask   = bus.i_req1 ? bus.i_mask1 : '0;
      end
      default: ;
    endcase
  end

  assign bus.o_gnt0    = gnt0;
  assign bus.o_gnt1    = gnt1;
  assign bus.o_rvalid0 = rvalid0;
  assign bus.o_rvalid1 = rvalid1;
  assign bus.o_rdata   = rdata;

endmodule
